// File: rtl/dvsd_param_updown_counter.sv
// dvsd_param_updown_counter: parametrised up/down counter with modulus, wrap/saturate,
// clock-enable prescaler, synchronous load and registered terminal-count pulse.
module dvsd_param_updown_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             at_limit
);
    localparam int               PW    = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PC_END = PW'(PRESCALE - 1);

    if (MODULUS > (64'd1 << WIDTH) || MODULUS < 2 || PRESCALE == 0 || WIDTH < 1 || WIDTH > 32) begin : g_bad_params
        $error("dvsd_param_updown_counter: illegal WIDTH/MODULUS/PRESCALE");
    end

    logic [PW-1:0]    r_pc;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             w_step;
    logic             w_lim;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_ld;

    assign w_step   = en && (r_pc == PC_END);
    assign w_lim    = updown ? (r_out == MAX_W) : (r_out == '0);
    // At a limit the counter either holds (saturate) or jumps to the opposite end
    assign w_nxt    = w_lim ? ((SATURATE != 0) ? r_out : (updown ? '0 : MAX_W))
                            : (updown ? r_out + 1'b1 : r_out - 1'b1);
    assign w_ld     = ({1'b0, load_val} >= MOD_X) ? MAX_W : load_val;
    assign out      = r_out;
    assign tc       = r_tc;
    assign at_limit = w_lim;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
            r_pc  <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= w_ld;
            r_pc  <= '0;
            r_tc  <= 1'b0;
        end else if (en) begin
            r_pc  <= w_step ? '0 : r_pc + PW'(1);
            r_out <= w_step ? w_nxt : r_out;
            r_tc  <= w_step && w_lim;
        end else begin
            r_tc  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dvsd_param_updown_counter.sv
// tb_dvsd_param_updown_counter: drives four parameter variants with shared stimulus and
// checks them against constant tables, closed-form sequences and a behavioural model.
module tb_dvsd_param_updown_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       updown = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] d_out [4];
    logic       d_tc  [4];
    logic       d_lim [4];

    int MOD [4] = '{16, 10, 16, 10};
    int SAT [4] = '{0, 0, 1, 0};
    int PRE [4] = '{1, 3, 1, 1};

    int m_cnt [4];
    int m_pc  [4];
    int m_tc  [4];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dvsd_param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load), .load_val(load_val),
        .out(d_out[0]), .tc(d_tc[0]), .at_limit(d_lim[0]));
    dvsd_param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_b (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load), .load_val(load_val),
        .out(d_out[1]), .tc(d_tc[1]), .at_limit(d_lim[1]));
    dvsd_param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .PRESCALE(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load), .load_val(load_val),
        .out(d_out[2]), .tc(d_tc[2]), .at_limit(d_lim[2]));
    dvsd_param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_d (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load), .load_val(load_val),
        .out(d_out[3]), .tc(d_tc[3]), .at_limit(d_lim[3]));

    function automatic int ref_next(int i, int c, logic up);
        if (up) return SAT[i] != 0 ? ((c + 1 > MOD[i] - 1) ? MOD[i] - 1 : c + 1) : (c + 1) % MOD[i];
        return SAT[i] != 0 ? ((c - 1 < 0) ? 0 : c - 1) : (c + MOD[i] - 1) % MOD[i];
    endfunction

    function automatic int ref_lim(int i, int c, logic up);
        return up ? int'(c == MOD[i] - 1) : int'(c == 0);
    endfunction

    // Reference model: integer count plus a count of enabled cycles toward the next step
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset) begin
                m_cnt[i] <= 0;
                m_pc[i]  <= 0;
                m_tc[i]  <= 0;
            end else if (load) begin
                m_cnt[i] <= (int'(load_val) >= MOD[i]) ? MOD[i] - 1 : int'(load_val);
                m_pc[i]  <= 0;
                m_tc[i]  <= 0;
            end else if (en && m_pc[i] == PRE[i] - 1) begin
                m_pc[i]  <= 0;
                m_cnt[i] <= ref_next(i, m_cnt[i], updown);
                m_tc[i]  <= ref_lim(i, m_cnt[i], updown);
            end else begin
                m_pc[i]  <= en ? m_pc[i] + 1 : m_pc[i];
                m_tc[i]  <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_model();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("inst%0d out", i), int'(d_out[i]), m_cnt[i]);
            chk($sformatf("inst%0d tc", i), int'(d_tc[i]), m_tc[i]);
            chk($sformatf("inst%0d at_limit", i), int'(d_lim[i]), ref_lim(i, m_cnt[i], updown));
        end
    endtask

    task automatic cyc(input logic e, input logic u, input logic l, input logic [3:0] v);
        en = e;
        updown = u;
        load = l;
        load_val = v;
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       en, up, ld;
        logic [3:0] lv;
        int         a_out, a_tc, d_out, d_tc, d_lim;
    } vec_t;

    vec_t tv [10];

    initial begin
        tv = '{
            '{1'b1, 1'b1, 1'b1, 4'd7,  7,  0, 7, 0, 0},
            '{1'b1, 1'b0, 1'b0, 4'd0,  6,  0, 6, 0, 0},
            '{1'b1, 1'b1, 1'b1, 4'd12, 12, 0, 9, 0, 1},
            '{1'b1, 1'b1, 1'b0, 4'd0,  13, 0, 0, 1, 0},
            '{1'b1, 1'b0, 1'b0, 4'd0,  12, 0, 9, 1, 0},
            '{1'b0, 1'b0, 1'b0, 4'd0,  12, 0, 9, 0, 0},
            '{1'b0, 1'b0, 1'b1, 4'd0,  0,  0, 0, 0, 1},
            '{1'b1, 1'b1, 1'b0, 4'd0,  1,  0, 1, 0, 0},
            '{1'b0, 1'b1, 1'b1, 4'd15, 15, 0, 9, 0, 1},
            '{1'b1, 1'b1, 1'b0, 4'd0,  0,  1, 0, 1, 0}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", int'(d_out[0]), 0);
        chk("reset tc", int'(d_tc[0]), 0);
        check_model();
        reset = 1'b1;

        for (int k = 1; k <= 18; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0);
            chk("t1 wrap out", int'(d_out[0]), k % 16);
            chk("t1 wrap tc", int'(d_tc[0]), int'(k == 16));
            chk("t1 prescale out", int'(d_out[1]), (k / 3) % 10);
            chk("t1 sat out", int'(d_out[2]), k > 15 ? 15 : k);
            chk("t1 sat tc", int'(d_tc[2]), int'(k >= 16));
            chk("t1 mod10 out", int'(d_out[3]), k % 10);
        end

        foreach (tv[j]) begin
            cyc(tv[j].en, tv[j].up, tv[j].ld, tv[j].lv);
            chk($sformatf("vec%0d a out", j), int'(d_out[0]), tv[j].a_out);
            chk($sformatf("vec%0d a tc", j), int'(d_tc[0]), tv[j].a_tc);
            chk($sformatf("vec%0d d out", j), int'(d_out[3]), tv[j].d_out);
            chk($sformatf("vec%0d d tc", j), int'(d_tc[3]), tv[j].d_tc);
            chk($sformatf("vec%0d d at_limit", j), int'(d_lim[3]), tv[j].d_lim);
        end

        cyc(1'b1, 1'b0, 1'b1, 4'd0);
        for (int k = 1; k <= 11; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0);
            chk("t2 down out", int'(d_out[3]), (10 - k % 10) % 10);
            chk("t2 down tc", int'(d_tc[3]), int'(k % 10 == 1));
            chk("t2 at_limit", int'(d_lim[3]), int'(k == 10));
        end

        cyc(1'b0, 1'b1, 1'b1, 4'd13);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0);
            chk("t3 sat out", int'(d_out[2]), 13 + k > 15 ? 15 : 13 + k);
            chk("t3 sat tc", int'(d_tc[2]), int'(k >= 3));
        end

        cyc(1'b0, 1'b1, 1'b1, 4'd0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 4'd0);
        chk("t4 mid period", int'(d_out[1]), 0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 4'd0);
        chk("t4 frozen", int'(d_out[1]), 0);
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        chk("t4 resume step", int'(d_out[1]), 1);

        cyc(1'b0, 1'b1, 1'b1, 4'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 async reset out", int'(d_out[0]), 0);
        check_model();
        #1;
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 4'd3);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        chk("t6 direction flip", int'(d_out[0]), 2);

        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(63) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                check_model();
                #1;
                reset = 1'b1;
            end
            cyc(1'($urandom_range(7) != 0), 1'($urandom_range(1)), 1'($urandom_range(15) == 0),
                4'($urandom_range(15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
